hyperram_register_write: RTL

- HyperBus host-side configuration-register writer; the write counterpart of the HyperRAM register-read block.
- On a start pulse, issues one zero-latency register-write transaction: 48-bit CA, then one 16-bit register word, then CS release and recovery.
- Drives SDR-packed DQ words to external ODDRE1 primitives, plus CS#, CK enable and DQ tri-state enable.
- Sits between the memory-controller init sequencer and the HyperRAM pads.

---
 rtl/hyperram_register_write.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hyperram_register_write.sv
// HyperBus zero-latency configuration-register writer: CA, one data word, CS# release, tRWR recovery.
// Optional `HYPERRAM_CR0_GUARD_EN forces CR0 reserved bits [11:8] high and adds the cfg_fixup output.
module hyperram_register_write #(
  parameter int unsigned RECOVERY_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        reg_sel,
  input  logic [15:0] wr_data,
  output logic        cs_n,
  output logic        ck_en,
  output logic        dq_tx_en,
  output logic [31:0] o_sdr_dq,
  output logic        busy,
  output logic        done
`ifdef HYPERRAM_CR0_GUARD_EN
  ,
  output logic        cfg_fixup
`endif
);

  typedef enum logic [2:0] {
    IDLE, CSS, CA0, CA1, CA2, DATA, CSH, REC
  } state_e;

  localparam logic [47:0]      CA_CR0   = 48'h6000_0100_0000;
  localparam logic [CNT_W-1:0] REC_LAST = (RECOVERY_CYCLES == 0) ? '0 : CNT_W'(RECOVERY_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [47:0]       ca_q, ca_d;
  logic [15:0]       data_q, data_d;
  logic              cs_n_q, cs_n_d;
  logic              ck_en_q, ck_en_d;
  logic              dq_tx_en_q, dq_tx_en_d;
  logic [31:0]       sdr_q, sdr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       cap_data;
`ifdef HYPERRAM_CR0_GUARD_EN
  logic              cfg_fixup_q, cfg_fixup_d;
`endif

  // Value that would be captured if start is accepted this cycle.
  always_comb begin
    cap_data = wr_data;
`ifdef HYPERRAM_CR0_GUARD_EN
    if (!reg_sel) begin
      cap_data = wr_data | 16'h0F00;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ca_d    = ca_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CSS;
          ca_d    = CA_CR0 | {47'd0, reg_sel};
          data_d  = cap_data;
        end
      end
      CSS:  state_d = CA0;
      CA0:  state_d = CA1;
      CA1:  state_d = CA2;
      CA2:  state_d = DATA;
      DATA: state_d = CSH;
      CSH: begin
        cnt_d = '0;
        if (RECOVERY_CYCLES == 0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = REC;
        end
      end
      REC: begin
        if (cnt_q == REC_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    cs_n_d     = !(state_d inside {CSS, CA0, CA1, CA2, DATA, CSH});
    dq_tx_en_d = state_d inside {CSS, CA0, CA1, CA2, DATA};
    ck_en_d    = state_d inside {CA0, CA1, CA2, DATA};
    busy_d     = (state_d != IDLE);
    sdr_d      = 32'd0;
    case (state_d)
      CA0:     sdr_d = {8'h00, ca_q[39:32], 8'h00, ca_q[47:40]};
      CA1:     sdr_d = {8'h00, ca_q[23:16], 8'h00, ca_q[31:24]};
      CA2:     sdr_d = {8'h00, ca_q[7:0],   8'h00, ca_q[15:8]};
      DATA:    sdr_d = {8'h00, data_q[7:0], 8'h00, data_q[15:8]};
      default: sdr_d = 32'd0;
    endcase
`ifdef HYPERRAM_CR0_GUARD_EN
    cfg_fixup_d = (state_q == IDLE) && start && (cap_data != wr_data);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ca_q        <= '0;
      data_q      <= '0;
      cs_n_q      <= 1'b1;
      ck_en_q     <= 1'b0;
      dq_tx_en_q  <= 1'b0;
      sdr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef HYPERRAM_CR0_GUARD_EN
      cfg_fixup_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ca_q        <= ca_d;
      data_q      <= data_d;
      cs_n_q      <= cs_n_d;
      ck_en_q     <= ck_en_d;
      dq_tx_en_q  <= dq_tx_en_d;
      sdr_q       <= sdr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef HYPERRAM_CR0_GUARD_EN
      cfg_fixup_q <= cfg_fixup_d;
`endif
    end
  end

  assign cs_n     = cs_n_q;
  assign ck_en    = ck_en_q;
  assign dq_tx_en = dq_tx_en_q;
  assign o_sdr_dq = sdr_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef HYPERRAM_CR0_GUARD_EN
  assign cfg_fixup = cfg_fixup_q;
`endif

endmodule
